mdu: RTL and testbench
======================

# mdu

Sequential 16-bit multiply/divide unit. It runs the multiplicative arithmetic that the single-cycle add/sub/shift unit cannot do in one cycle. It takes operands from the execute stage through a valid/ready handshake and iterates for 16 cycles. It then returns a 32-bit result (low and high words) with the same carry/overflow flag semantics used by the rest of the datapath.

## Interface
Parameters:
- `WIDTH`, 16: operand width; only 16 is supported and verified.

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operands and opcode valid.
- `in_ready`  out  1  unit idle and able to accept.
- `opcode`  in  3  000 MUL, 001 MULS, 010 DIV, 011 DIVS; bit 2 is ignored.
- `arg1`  in  16  multiplicand / dividend.
- `arg2`  in  16  multiplier / divisor.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer takes result.
- `result`  out  16  product low word / quotient.
- `result_hi`  out  16  product high word / remainder.
- `carry`  out  1  MUL: `result_hi != 0`; other opcodes 0.
- `overflow`  out  1  MULS: product not representable in signed 16 bits; DIVS: 0x8000 / 0xFFFF; otherwise 0.
- `div_zero`  out  1  DIV/DIVS with `arg2 == 0`.

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid`, latch opcode, signedness and operand signs, and load operand magnitudes.
  - Signed opcodes negate negative operands. Magnitude of 0x8000 is 0x8000, treated as unsigned.
  - Clear the iteration counter, then go to CALC.
  - Exception: a divide with `arg2 == 0` goes straight to DONE.
- CALC: runs exactly 16 cycles; the counter 0..15 exits to FIX when the counter reads 15.
  - Multiply: radix-2 shift-add on a 32-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first, with a 17-bit partial remainder.
- FIX (1 cycle):
  - Apply signs. Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ; it truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Compute `carry` and `overflow`, register all outputs, then go to DONE.
- DONE:
  - `out_valid = 1`; all outputs held stable until `out_ready`.
  - When `out_valid && out_ready`, return to IDLE and drop `out_valid`.
- Divide by zero: `result = 0xFFFF`, `result_hi = arg1` (raw), `div_zero = 1`, `carry = overflow = 0`.
- DIVS 0x8000 / 0xFFFF: `result = 0x8000`, `result_hi = 0`, `overflow = 1`.
- `in_ready` is 0 in every state except IDLE. There is no overlap between operations, and input changes while not in IDLE are ignored.
- Flags and results are cleared to 0 on each accept and are valid only while `out_valid = 1`.

## Timing
- Reset (asynchronous, any state including mid-CALC):
  - State goes to IDLE; counter is cleared.
  - `in_ready = 1`, `out_valid = 0`.
  - `result`, `result_hi`, `carry`, `overflow`, `div_zero` all reset to 0.
  - The in-flight operation is discarded.
- Latency: with the handshake in cycle 0, `out_valid` rises in cycle 18 (16 CALC + 1 FIX + DONE). Divide-by-zero: `out_valid` in cycle 1.
- Throughput: with `out_ready` tied high, one operation per 19 cycles. The next accept can happen in the cycle after the result handshake.
- Backpressure: DONE is held indefinitely and outputs do not change. `in_ready` stays 0.
- `out_valid` and `in_ready` are never high in the same cycle.

## Structure
- Shared package `mdu_pkg`:
  - opcode constants `MDU_MUL`, `MDU_MULS`, `MDU_DIV`, `MDU_DIVS`;
  - state enum `mdu_state_t`;
  - `MDU_ITER = 16`.
- Single module, FSM plus datapath, with no sub-module. The conditional two's-complement negate is a local function reused in the IDLE and FIX steps.

## Test plan
- MUL 0x1234 × 0x0100 → `result` 0x3400, `result_hi` 0x0012, `carry` 1, `out_valid` in cycle 18.
- MULS 0xFFFE × 0x0003 → 0xFFFA / 0xFFFF, `overflow` 0. MULS 0x0100 × 0x0100 → 0x0000 / 0x0001, `overflow` 1.
- DIVS 0xFFF9 / 0x0002 → quotient 0xFFFD, remainder 0xFFFF. DIV 0xFFFF / 0x0010 → 0x0FFF / 0x000F.
- DIV 0x1234 / 0 → 0xFFFF / 0x1234, `div_zero` 1 in cycle 1. DIVS 0x8000 / 0xFFFF → 0x8000 / 0, `overflow` 1.
- Hold `out_ready` low 5 cycles after DONE → outputs stable, `in_ready` 0; release → IDLE next cycle.
- Assert `rst_n` low in CALC iteration 7 → all outputs 0 immediately. A new MUL 3 × 5 after release → 0x000F in cycle 18.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants and state type for the sequential multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] MDU_MUL  = 3'b000;
  localparam logic [2:0] MDU_MULS = 3'b001;
  localparam logic [2:0] MDU_DIV  = 3'b010;
  localparam logic [2:0] MDU_DIVS = 3'b011;

  localparam int MDU_ITER = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// Sequential 16-bit multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up and flag generation in a final cycle.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] arg1,
  input  logic [WIDTH-1:0] arg2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             overflow,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(MDU_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_ITER - 1);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  mdu_state_t           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_div;
  logic                 r_signed;
  logic                 r_sgn1;
  logic                 r_sgn2;
  logic                 r_divs_ovf;
  logic [WIDTH-1:0]     r_mag1;
  logic [WIDTH-1:0]     r_mag2;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_result;
  logic [WIDTH-1:0]     r_result_hi;
  logic                 r_carry;
  logic                 r_overflow;
  logic                 r_div_zero;

  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_sgn1;
  logic                 w_sgn2;
  logic [2*WIDTH-1:0]   w_addend;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_trial;
  logic                 w_sub_ok;
  logic                 w_neg_p;
  logic [WIDTH-1:0]     w_prod_lo;
  logic [WIDTH-1:0]     w_prod_hi;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;

  // Opcode bit 2 is a don't-care, so decode only on the low two bits.
  always_comb begin
    w_is_div = 1'b0;
    w_signed = 1'b0;
    casez (opcode)
      3'b?00:  begin w_is_div = 1'b0; w_signed = 1'b0; end
      3'b?01:  begin w_is_div = 1'b0; w_signed = 1'b1; end
      3'b?10:  begin w_is_div = 1'b1; w_signed = 1'b0; end
      default: begin w_is_div = 1'b1; w_signed = 1'b1; end
    endcase
  end

  assign w_sgn1 = w_signed & arg1[WIDTH-1];
  assign w_sgn2 = w_signed & arg2[WIDTH-1];

  assign w_addend = {{WIDTH{1'b0}}, r_mag1} << r_cnt;
  assign w_shift  = {r_rem, r_mag1[WIDTH-1]};
  assign w_trial  = w_shift - {1'b0, r_mag2};
  assign w_sub_ok = ~w_trial[WIDTH];

  // Two-word negate: high word borrows unless the low word is zero.
  assign w_neg_p   = r_signed & (r_sgn1 ^ r_sgn2);
  assign w_prod_lo = cond_neg(r_acc[WIDTH-1:0], w_neg_p);
  assign w_prod_hi = cond_neg(r_acc[2*WIDTH-1:WIDTH], w_neg_p)
                   - {{(WIDTH-1){1'b0}}, w_neg_p & (r_acc[WIDTH-1:0] != '0)};
  assign w_quo     = cond_neg(r_mag1, w_neg_p);
  assign w_rem     = cond_neg(r_rem, r_signed & r_sgn1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_is_div    <= 1'b0;
      r_signed    <= 1'b0;
      r_sgn1      <= 1'b0;
      r_sgn2      <= 1'b0;
      r_divs_ovf  <= 1'b0;
      r_mag1      <= '0;
      r_mag2      <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_result    <= '0;
            r_result_hi <= '0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_div_zero  <= 1'b0;
            r_cnt       <= '0;
            r_is_div    <= w_is_div;
            r_signed    <= w_signed;
            r_sgn1      <= w_sgn1;
            r_sgn2      <= w_sgn2;
            r_mag1      <= cond_neg(arg1, w_sgn1);
            r_mag2      <= cond_neg(arg2, w_sgn2);
            r_acc       <= '0;
            r_rem       <= '0;
            r_divs_ovf  <= w_is_div & w_signed & (arg1 == {1'b1, {(WIDTH-1){1'b0}}})
                           & (arg2 == {WIDTH{1'b1}});
            if (w_is_div && (arg2 == '0)) begin
              r_result    <= '1;
              r_result_hi <= arg1;
              r_div_zero  <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state     <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (r_is_div) begin
            r_rem  <= w_sub_ok ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_mag1 <= {r_mag1[WIDTH-2:0], w_sub_ok};
          end else begin
            if (r_mag2[0]) begin
              r_acc <= r_acc + w_addend;
            end
            r_mag2 <= r_mag2 >> 1;
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (r_is_div) begin
            r_result    <= w_quo;
            r_result_hi <= w_rem;
            r_overflow  <= r_divs_ovf;
          end else begin
            r_result    <= w_prod_lo;
            r_result_hi <= w_prod_hi;
            r_carry     <= ~r_signed & (w_prod_hi != '0);
            r_overflow  <= r_signed & (w_prod_hi != {WIDTH{w_prod_lo[WIDTH-1]}});
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign carry     = r_carry;
  assign overflow  = r_overflow;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_mdu.sv
// Directed and randomized checks of mdu against a plain-arithmetic reference model.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  opcode;
  logic [15:0] arg1;
  logic [15:0] arg2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        carry;
  logic        overflow;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mdu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .arg1(arg1), .arg2(arg2), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .carry(carry), .overflow(overflow), .div_zero(div_zero)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: ordinary integer arithmetic on the operand values.
  function automatic void model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [15:0] h,
                                output logic c, output logic o, output logic z);
    longint ua, ub, sa, sb, p, q, m;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; h = '0; c = 1'b0; o = 1'b0; z = 1'b0;
    p = 0; q = 0; m = 0;
    case (op[1:0])
      2'b00: begin
        p = ua * ub;
        r = p[15:0]; h = p[31:16]; c = (p >= 65536);
      end
      2'b01: begin
        p = sa * sb;
        r = p[15:0]; h = p[31:16]; o = (p > 32767) || (p < -32768);
      end
      2'b10: begin
        if (b == 16'h0) begin
          r = 16'hFFFF; h = a; z = 1'b1;
        end else begin
          q = ua / ub; m = ua % ub;
          r = q[15:0]; h = m[15:0];
        end
      end
      default: begin
        if (b == 16'h0) begin
          r = 16'hFFFF; h = a; z = 1'b1;
        end else if (a == 16'h8000 && b == 16'hFFFF) begin
          r = 16'h8000; h = 16'h0; o = 1'b1;
        end else begin
          q = sa / sb; m = sa % sb;
          r = q[15:0]; h = m[15:0];
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int hold);
    logic [15:0] er, eh;
    logic        ec, eo, ez;
    int          n, lat, exp_lat;
    logic        busy_bad;
    model(op, a, b, er, eh, ec, eo, ez);
    exp_lat = ez ? 1 : 18;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_idle", 40'(in_ready), 40'(1));
    in_valid = 1'b1; opcode = op; arg1 = a; arg2 = b; out_ready = 1'b0;
    @(negedge clk);
    in_valid = $urandom_range(0, 1);
    opcode = 3'($urandom); arg1 = 16'($urandom); arg2 = 16'($urandom);
    lat = 1;
    busy_bad = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("busy_in_ready", 40'(busy_bad), 40'(0));
    chk("latency", 40'(lat), 40'(exp_lat));
    chk("result", 40'(result), 40'(er));
    chk("result_hi", 40'(result_hi), 40'(eh));
    chk("flags_cozr", 40'({carry, overflow, div_zero, in_ready}), 40'({ec, eo, ez, 1'b0}));
    $display("TXN op=%0d a=%h b=%h result=%h result_hi=%h c=%0b o=%0b z=%0b lat=%0d",
             op, a, b, result, result_hi, carry, overflow, div_zero, lat);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_stable", {result, result_hi, carry, overflow, div_zero, out_valid, in_ready},
          {er, eh, ec, eo, ez, 1'b1, 1'b0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_idle", 40'({out_valid, in_ready}), 40'({1'b0, 1'b1}));
  endtask

  initial begin
    logic [15:0] specials [5];
    logic [15:0] ra, rb;
    specials[0] = 16'h0000; specials[1] = 16'h0001; specials[2] = 16'h8000;
    specials[3] = 16'hFFFF; specials[4] = 16'h7FFF;

    rst_n = 1'b0; in_valid = 1'b0; opcode = '0; arg1 = '0; arg2 = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", {result, result_hi, carry, overflow, div_zero, out_valid, in_ready},
        {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    rst_n = 1'b1;
    @(negedge clk);

    run_op(MDU_MUL,  16'h1234, 16'h0100, 0);
    run_op(MDU_MULS, 16'hFFFE, 16'h0003, 0);
    run_op(MDU_MULS, 16'h0100, 16'h0100, 0);
    run_op(MDU_DIVS, 16'hFFF9, 16'h0002, 0);
    run_op(MDU_DIV,  16'hFFFF, 16'h0010, 0);
    run_op(MDU_DIV,  16'h1234, 16'h0000, 0);
    run_op(MDU_DIVS, 16'h8000, 16'hFFFF, 0);
    run_op(3'b100,   16'h8000, 16'h8000, 0);
    run_op(MDU_MUL,  16'hFFFF, 16'hFFFF, 5);

    // Reset while DONE holds a non-zero result must clear everything at once.
    in_valid = 1'b1; opcode = MDU_DIV; arg1 = 16'h1234; arg2 = 16'h0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_in_done", {result, result_hi, carry, overflow, div_zero, out_valid, in_ready},
        {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during CALC iteration 7 discards the operation.
    in_valid = 1'b1; opcode = MDU_MUL; arg1 = 16'hFFFF; arg2 = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_in_calc", {result, result_hi, carry, overflow, div_zero, out_valid, in_ready},
        {16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(MDU_MUL, 16'h0003, 16'h0005, 0);

    for (int k = 0; k < 40; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 16'h0;
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
